// File: rtl/pwm_pkg.sv
// Shared types for the PWM block family.
package pwm_pkg;

   typedef enum logic [1:0] {IDLE, HIGH, LOW} pwm_cap_state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchroniser for an asynchronous PWM input, plus a rise/fall detector on the synchronised level.
module pwm_edge_sync #(
   parameter int unsigned sync_depth = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic pwm_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [sync_depth-1:0] sync_q;
   logic                  level_dly_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q      <= '0;
         level_dly_q <= 1'b0;
      end else begin
         sync_q      <= {sync_q[sync_depth-2:0], pwm_in};
         level_dly_q <= sync_q[sync_depth-1];
      end
   end

   assign level = sync_q[sync_depth-1];
   assign rise  = level & ~level_dly_q;
   assign fall  = ~level & level_dly_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an incoming PWM waveform in clock cycles.
// Each completed period is reported with a one-cycle valid pulse.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int unsigned n_bit      = 10,
   parameter int unsigned sync_depth = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             pwm_in,
   output logic [n_bit-1:0] high_count,
   output logic [n_bit-1:0] period_count,
   output logic             valid,
   output logic             overflow
);

   localparam logic [n_bit-1:0] cnt_max = '1;
   localparam logic [n_bit-1:0] cnt_one = {{(n_bit-1){1'b0}}, 1'b1};

   pwm_cap_state_t   state_q, state_d;
   logic [n_bit-1:0] hcnt_q, hcnt_d, pcnt_q, pcnt_d;
   logic [n_bit-1:0] high_count_q, period_count_q;
   logic             valid_q, overflow_q;
   logic             publish, saturate;
   logic             pwm_s, rise, fall;
   logic             unused_level;

   pwm_edge_sync #(
      .sync_depth (sync_depth)
   ) u_edge_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .pwm_in  (pwm_in),
      .level   (pwm_s),
      .rise    (rise),
      .fall    (fall)
   );

   assign unused_level = pwm_s;

   // State, counters and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         hcnt_q         <= '0;
         pcnt_q         <= '0;
         high_count_q   <= '0;
         period_count_q <= '0;
         valid_q        <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         hcnt_q     <= hcnt_d;
         pcnt_q     <= pcnt_d;
         valid_q    <= publish;
         overflow_q <= saturate;
         if (publish) begin
            high_count_q   <= hcnt_q;
            period_count_q <= pcnt_q;
         end
      end
   end

   // Next state and counters; a rise in LOW takes priority over saturation.
   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      pcnt_d  = pcnt_q;
      if (!enable) begin
         state_d = IDLE;
         hcnt_d  = '0;
         pcnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rise) begin
                  state_d = HIGH;
                  hcnt_d  = cnt_one;
                  pcnt_d  = cnt_one;
               end
            end
            HIGH: begin
               if (saturate) begin
                  state_d = IDLE;
               end else if (fall) begin
                  state_d = LOW;
                  pcnt_d  = pcnt_q + cnt_one;
               end else begin
                  hcnt_d = hcnt_q + cnt_one;
                  pcnt_d = pcnt_q + cnt_one;
               end
            end
            LOW: begin
               if (rise) begin
                  state_d = HIGH;
                  hcnt_d  = cnt_one;
                  pcnt_d  = cnt_one;
               end else if (saturate) begin
                  state_d = IDLE;
               end else begin
                  pcnt_d = pcnt_q + cnt_one;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Publish/drop decisions, registered into valid/overflow.
   always_comb begin
      publish  = 1'b0;
      saturate = 1'b0;
      if (enable) begin
         publish  = (state_q == LOW) && rise;
         saturate = ((state_q == HIGH) || (state_q == LOW)) && (pcnt_q == cnt_max) && !rise;
      end
   end

   assign high_count   = high_count_q;
   assign period_count = period_count_q;
   assign valid        = valid_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: expected periods are queued as pwm_in is driven and checked on valid.
module tb_pwm_capture;

   localparam int unsigned NB = 10;
   localparam int unsigned SD = 2;

   typedef struct packed {
      logic [NB-1:0] h;
      logic [NB-1:0] p;
   } exp_t;

   logic          clock;
   logic          reset_n;
   logic          enable;
   logic          pwm_in;
   logic [NB-1:0] high_count;
   logic [NB-1:0] period_count;
   logic          valid;
   logic          overflow;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   ovf_cnt = 0;
   int   ovf_cycle = 0;
   int   c0, ovf0;
   exp_t sb[$];
   logic [NB-1:0] exp_hc = '0;
   logic [NB-1:0] exp_pc = '0;

   pwm_capture #(
      .n_bit      (NB),
      .sync_depth (SD)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .enable       (enable),
      .pwm_in       (pwm_in),
      .high_count   (high_count),
      .period_count (period_count),
      .valid        (valid),
      .overflow     (overflow)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Output monitor, sampled on the falling edge.
   always @(negedge clock) begin
      exp_t e;
      if (valid || overflow) check("valid_ovf_excl", {31'd0, valid & overflow}, 0);
      if (overflow) begin
         ovf_cnt++;
         ovf_cycle = cyc;
      end
      if (valid) begin
         check("sb_nonempty", {31'd0, sb.size() > 0}, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_hc = e.h;
            exp_pc = e.p;
            check("high_count", {22'd0, high_count}, {22'd0, e.h});
            check("period_count", {22'd0, period_count}, {22'd0, e.p});
         end
      end
   end

   // Holds pwm_in at lvl for exactly n sampling edges; returns off-edge.
   task automatic hold(input logic lvl, input int n);
      pwm_in = lvl;
      repeat (n) @(posedge clock);
      #($urandom_range(1, 8));
   endtask

   task automatic drive_period(input int h, input int l);
      exp_t e;
      e.h = NB'(h);
      e.p = NB'(h + l);
      sb.push_back(e);
      hold(1'b1, h);
      hold(1'b0, l);
   endtask

   // Closing rise publishes the last queued period, then disable.
   task automatic close_test();
      hold(1'b1, 4);
      enable = 1'b0;
      hold(1'b0, 8);
      check("sb_drained", sb.size(), 0);
   endtask

   initial begin
      reset_n = 1'b0;
      enable  = 1'b0;
      pwm_in  = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      check("rst_high_count", {22'd0, high_count}, 0);
      check("rst_period_count", {22'd0, period_count}, 0);
      check("rst_valid", {31'd0, valid}, 0);
      check("rst_overflow", {31'd0, overflow}, 0);
      reset_n = 1'b1;
      hold(1'b0, 4);

      // Direct drive, including single-cycle high pulse
      enable = 1'b1;
      hold(1'b0, 4);
      for (int i = 0; i < 3; i++) drive_period(5, 12);
      drive_period(1, 3);
      drive_period(1, 3);
      close_test();
      check("hold_high_count", {22'd0, high_count}, 1);
      check("hold_period_count", {22'd0, period_count}, 4);

      // Loopback-like waveform: 8-bit generator, threshold 100
      enable = 1'b1;
      hold(1'b0, 4);
      for (int i = 0; i < 3; i++) drive_period(155, 101);
      close_test();
      check("loop_period", {22'd0, period_count}, 256);

      // Constant high after a rise saturates the period counter
      enable = 1'b1;
      hold(1'b0, 4);
      ovf0 = ovf_cnt;
      c0   = cyc;
      hold(1'b1, 1100);
      check("ovf_count", ovf_cnt, ovf0 + 1);
      check("ovf_time", ovf_cycle - c0, SD + 1 + 1023);
      check("ovf_keep_hc", {22'd0, high_count}, {22'd0, exp_hc});
      check("ovf_keep_pc", {22'd0, period_count}, {22'd0, exp_pc});
      hold(1'b0, 6);
      hold(1'b1, 6);
      enable = 1'b0;
      hold(1'b0, 8);
      check("ovf_no_valid", sb.size(), 0);

      // Enable dropped mid-LOW, then re-enabled
      enable = 1'b1;
      hold(1'b0, 4);
      drive_period(4, 6);
      hold(1'b1, 4);
      hold(1'b0, 6);
      enable = 1'b0;
      hold(1'b0, 3);
      hold(1'b1, 4);
      hold(1'b0, 6);
      enable = 1'b1;
      hold(1'b0, 2);
      drive_period(3, 7);
      drive_period(2, 5);
      close_test();

      // Asynchronous reset mid-HIGH
      enable = 1'b1;
      hold(1'b0, 4);
      drive_period(6, 4);
      hold(1'b1, 5);
      check("pre_rst_pc", {22'd0, period_count}, 10);
      reset_n = 1'b0;
      #1;
      check("arst_high_count", {22'd0, high_count}, 0);
      check("arst_period_count", {22'd0, period_count}, 0);
      check("arst_valid", {31'd0, valid}, 0);
      check("arst_overflow", {31'd0, overflow}, 0);
      pwm_in = 1'b0;
      hold(1'b0, 3);
      reset_n = 1'b1;
      hold(1'b0, 4);
      drive_period(3, 5);
      drive_period(2, 6);
      close_test();

      // Random waveform
      enable = 1'b1;
      hold(1'b0, 4);
      for (int i = 0; i < 30; i++) drive_period($urandom_range(1, 20), $urandom_range(1, 20));
      close_test();
      check("total_overflows", ovf_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
